fft_radix2_iter_gen4: RTL

//  Parametrised N-point (N = 2**N_LOG2) iterative radix-2 DIT FFT/IFFT: next generation of the fixed 8-point FFT.

---
 rtl/fft_radix2_iter_gen4.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_radix2_iter_gen4.sv
// Iterative radix-2 DIT FFT/IFFT, N = 2**N_LOG2 points, one butterfly per cycle.
// Ports: in_* stream (valid/ready, inverse on n=0), out_* stream (valid/ready), done pulse.
module fft_radix2_iter_gen4 #(
  parameter int N_LOG2 = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              done
);
  localparam int N  = 1 << N_LOG2;
  localparam int PW = 2 * DATA_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (DATA_W - 2);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] mem_re [N];
  logic [DATA_W-1:0] mem_im [N];

  logic [N_LOG2-1:0] in_cnt;
  logic [2:0]        stage;
  logic [N_LOG2-2:0] bfly;
  logic              inv_q;

  logic bfly_last, stage_last, out_fire;

  function automatic logic [N_LOG2-1:0] bitrev(
    input logic [N_LOG2-1:0] v
  );
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  // First quadrant of cos(2*pi*k/64) in Q1.15; the rest follows by symmetry.
  function automatic logic [15:0] qcos(input logic [4:0] k);
    logic [15:0] c;
    case (k)
      5'd0:  c = 16'h7FFF;
      5'd1:  c = 16'h7F62;
      5'd2:  c = 16'h7D8A;
      5'd3:  c = 16'h7A7D;
      5'd4:  c = 16'h7642;
      5'd5:  c = 16'h70E3;
      5'd6:  c = 16'h6A6E;
      5'd7:  c = 16'h62F2;
      5'd8:  c = 16'h5A82;
      5'd9:  c = 16'h5134;
      5'd10: c = 16'h471D;
      5'd11: c = 16'h3C57;
      5'd12: c = 16'h30FC;
      5'd13: c = 16'h2528;
      5'd14: c = 16'h18F9;
      5'd15: c = 16'h0C8C;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic signed [PW-1:0] sx(
    input logic [DATA_W-1:0] v
  );
    return PW'($signed(v));
  endfunction

  logic [N_LOG2-1:0] j, half, pos, addr_a, addr_b;
  logic [4:0]        tw_idx;
  logic [15:0]       c16, s16, wi16;
  logic [DATA_W-1:0] w_re, w_im;
  logic [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [DATA_W:0]   t_re, t_im;
  logic signed [DATA_W+1:0] s_ar, s_ai, s_br, s_bi;

  always_comb begin
    j      = {1'b0, bfly};
    half   = N_LOG2'(1) << stage;
    pos    = j & (half - N_LOG2'(1));
    addr_a = ((j >> stage) << (stage + 3'd1)) | pos;
    addr_b = addr_a | half;
    tw_idx = 5'(pos) << (3'd5 - stage);

    c16 = (tw_idx <= 5'd16) ? qcos(tw_idx)
                            : -qcos(5'd0 - tw_idx);
    s16 = 16'h0000;
    if (tw_idx == 5'd16)     s16 = 16'h8000;
    else if (tw_idx == 5'd0) s16 = 16'h0000;
    else if (tw_idx < 5'd16) s16 = -qcos(5'd16 - tw_idx);
    else                     s16 = -qcos(tw_idx - 5'd16);
    wi16 = s16;
    if (inv_q) wi16 = (s16 == 16'h8000) ? 16'h7FFF : -s16;

    // Rescale the Q1.15 twiddle to DATA_W fraction bits.
    w_re = DATA_W'($signed({c16, {DATA_W{1'b0}}}) >>> 16);
    w_im = DATA_W'($signed({wi16, {DATA_W{1'b0}}}) >>> 16);

    a_re = mem_re[addr_a];
    a_im = mem_im[addr_a];
    b_re = mem_re[addr_b];
    b_im = mem_im[addr_b];

    p_re = sx(b_re) * sx(w_re) - sx(b_im) * sx(w_im) + RND;
    p_im = sx(b_re) * sx(w_im) + sx(b_im) * sx(w_re) + RND;
    t_re = (DATA_W+1)'(p_re >>> (DATA_W - 1));
    t_im = (DATA_W+1)'(p_im >>> (DATA_W - 1));

    s_ar = (DATA_W+2)'($signed(a_re)) + (DATA_W+2)'(t_re);
    s_ai = (DATA_W+2)'($signed(a_im)) + (DATA_W+2)'(t_im);
    s_br = (DATA_W+2)'($signed(a_re)) - (DATA_W+2)'(t_re);
    s_bi = (DATA_W+2)'($signed(a_im)) - (DATA_W+2)'(t_im);
  end

  assign in_ready   = (state == LOAD);
  assign bfly_last  = &bfly;
  assign stage_last = (stage == 3'(N_LOG2 - 1));
  assign out_fire   = out_valid && out_ready;
  assign out_last   = out_valid && (&out_index);
  assign done       = out_fire && out_last;

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (in_valid && (&in_cnt)) state_nx = COMPUTE;
      COMPUTE: if (bfly_last && stage_last) state_nx = UNLOAD;
      UNLOAD:  if (done) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_cnt    <= '0;
      stage     <= '0;
      bfly      <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      unique case (state)
        LOAD: if (in_valid) begin
          in_cnt <= in_cnt + N_LOG2'(1);
          if (in_cnt == '0) inv_q <= inverse;
        end
        COMPUTE: begin
          bfly <= bfly + (N_LOG2-1)'(1);
          if (bfly_last) stage <= stage_last ? 3'd0 : stage + 3'd1;
        end
        UNLOAD: begin
          // First UNLOAD cycle fills the output register from memory.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_real  <= mem_re[out_index];
            out_imag  <= mem_im[out_index];
          end else if (out_ready) begin
            if (&out_index) begin
              out_valid <= 1'b0;
              out_index <= '0;
            end else begin
              out_index <= out_index + N_LOG2'(1);
              out_real  <= mem_re[out_index + N_LOG2'(1)];
              out_imag  <= mem_im[out_index + N_LOG2'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == LOAD && in_valid) begin
      mem_re[bitrev(in_cnt)] <= in_real;
      mem_im[bitrev(in_cnt)] <= in_imag;
    end else if (rst && state == COMPUTE) begin
      mem_re[addr_a] <= DATA_W'(s_ar >>> 1);
      mem_im[addr_a] <= DATA_W'(s_ai >>> 1);
      mem_re[addr_b] <= DATA_W'(s_br >>> 1);
      mem_im[addr_b] <= DATA_W'(s_bi >>> 1);
    end
  end
endmodule
